// File: rtl/muldiv_ctrl_pkg.sv
// ============================================================================
// Module   : muldiv_ctrl_pkg
// Brief    : Op codes, controller states and defaults for the HI/LO sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DIV_RUN  = 2'd1,
    ST_DIV_HOLD = 2'd2,
    ST_ABORT    = 2'd3
  } md_state_e;

  localparam int c_DIV_TIMEOUT_DFLT = 40;

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_ctrl_if.sv
// ============================================================================
// Module   : muldiv_ctrl_if
// Brief    : EX-side, divider-side and HI/LO-write signals of muldiv_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface muldiv_ctrl_if;
  import muldiv_ctrl_pkg::*;

  // Names are from the controller's point of view: i_* into it, o_* out of it.
  logic         i_op_valid;
  md_op_e       i_op;
  logic [31:0]  i_src_a;
  logic [31:0]  i_src_b;
  logic [31:0]  i_hi_in;
  logic [31:0]  i_lo_in;
  logic         i_flush_e;
  logic         i_stall_m;
  logic [63:0]  i_mul_result;
  logic         i_div_res_valid;
  logic [63:0]  i_div_result;

  logic         o_div_opn_valid;
  logic         o_div_sign;
  logic [31:0]  o_div_a;
  logic [31:0]  o_div_b;
  logic         o_div_res_ready;
  logic         o_div_abort;
  logic         o_stall_e;
  logic         o_hilo_we;
  logic [63:0]  o_hilo_wdata;
  logic         o_err_timeout;

  modport slave (
    input  i_op_valid, i_op, i_src_a, i_src_b, i_hi_in, i_lo_in,
    input  i_flush_e, i_stall_m, i_mul_result, i_div_res_valid, i_div_result,
    output o_div_opn_valid, o_div_sign, o_div_a, o_div_b, o_div_res_ready,
    output o_div_abort, o_stall_e, o_hilo_we, o_hilo_wdata, o_err_timeout
  );

  modport master (
    output i_op_valid, i_op, i_src_a, i_src_b, i_hi_in, i_lo_in,
    output i_flush_e, i_stall_m, i_mul_result, i_div_res_valid, i_div_result,
    input  o_div_opn_valid, o_div_sign, o_div_a, o_div_b, o_div_res_ready,
    input  o_div_abort, o_stall_e, o_hilo_we, o_hilo_wdata, o_err_timeout
  );

endinterface

`default_nettype wire

// File: rtl/muldiv_ctrl_timer.sv
// ============================================================================
// Module   : muldiv_ctrl_timer
// Brief    : Counts divider run cycles; one-cycle pulse on the DIV_TIMEOUT-th.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_ctrl_timer #(
  parameter int DIV_TIMEOUT = 40
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_run,
  output logic      o_expire
);

  localparam int               c_CW   = $clog2(DIV_TIMEOUT + 1);
  localparam logic [c_CW-1:0]  c_LAST = c_CW'(DIV_TIMEOUT - 1);
  localparam logic [c_CW-1:0]  c_SAT  = c_CW'(DIV_TIMEOUT);

  logic [c_CW-1:0] r_cnt;

  // Saturating so the pulse cannot repeat while the divider keeps stalling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_run) begin
      r_cnt <= '0;
    end else if (r_cnt != c_SAT) begin
      r_cnt <= r_cnt + c_CW'(1);
    end
  end

  assign o_expire = i_run && (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/muldiv_ctrl.sv
// ============================================================================
// Module   : muldiv_ctrl
// Brief    : Sequences MULT/DIV/MTHI/MTLO in EX, one HI/LO write per op.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int DIV_TIMEOUT = c_DIV_TIMEOUT_DFLT
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  muldiv_ctrl_if.slave  bus
);

  md_state_e   r_state;
  md_state_e   w_state_nxt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_sign;
  logic [63:0] r_res;

  logic        w_opn_valid;
  logic        w_res_ready;
  logic        w_abort;
  logic        w_stall;
  logic        w_we;
  logic [63:0] w_wdata;
  logic        w_latch_ops;
  logic        w_clr_ops;
  logic        w_latch_res;
  logic        w_run;
  logic        w_expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sign  <= 1'b0;
      r_res   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch_ops) begin
        r_a    <= bus.i_src_a;
        r_b    <= bus.i_src_b;
        r_sign <= (bus.i_op == MD_DIV);
      end else if (w_clr_ops) begin
        r_a    <= '0;
        r_b    <= '0;
        r_sign <= 1'b0;
      end
      if (w_latch_res) begin
        r_res <= bus.i_div_result;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_opn_valid = 1'b0;
    w_res_ready = 1'b0;
    w_abort     = 1'b0;
    w_stall     = 1'b0;
    w_we        = 1'b0;
    w_wdata     = '0;
    w_latch_ops = 1'b0;
    w_clr_ops   = 1'b0;
    w_latch_res = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.i_op_valid && !bus.i_flush_e) begin
          if (md_is_div(bus.i_op)) begin
            w_latch_ops = 1'b1;
            w_stall     = 1'b1;
            w_state_nxt = ST_DIV_RUN;
          end else if (!bus.i_stall_m) begin
            case (bus.i_op)
              MD_MULT, MD_MULTU: begin
                w_we    = 1'b1;
                w_wdata = bus.i_mul_result;
              end
              MD_MTHI: begin
                w_we    = 1'b1;
                w_wdata = {bus.i_src_a, bus.i_lo_in};
              end
              MD_MTLO: begin
                w_we    = 1'b1;
                w_wdata = {bus.i_hi_in, bus.i_src_a};
              end
              default: ;
            endcase
          end
        end
      end

      ST_DIV_RUN: begin
        // A flush wins over a result arriving in the same cycle.
        if (bus.i_flush_e) begin
          w_abort     = 1'b1;
          w_clr_ops   = 1'b1;
          w_state_nxt = ST_ABORT;
        end else begin
          w_opn_valid = 1'b1;
          if (bus.i_div_res_valid && !bus.i_stall_m) begin
            w_res_ready = 1'b1;
            w_we        = 1'b1;
            w_wdata     = bus.i_div_result;
            w_state_nxt = ST_IDLE;
          end else begin
            w_stall = 1'b1;
            if (bus.i_div_res_valid) begin
              w_latch_res = 1'b1;
              w_state_nxt = ST_DIV_HOLD;
            end
          end
        end
      end

      ST_DIV_HOLD: begin
        if (bus.i_flush_e) begin
          w_abort     = 1'b1;
          w_clr_ops   = 1'b1;
          w_state_nxt = ST_ABORT;
        end else if (!bus.i_stall_m) begin
          // Stall drops on the commit cycle so EX retires the divide exactly once.
          w_res_ready = 1'b1;
          w_we        = 1'b1;
          w_wdata     = r_res;
          w_state_nxt = ST_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end

      ST_ABORT: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_run = (r_state == ST_DIV_RUN) && !bus.i_flush_e;

  muldiv_ctrl_timer #(
    .DIV_TIMEOUT (DIV_TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_run    (w_run),
    .o_expire (w_expire)
  );

  assign bus.o_div_opn_valid = w_opn_valid;
  assign bus.o_div_sign      = r_sign;
  assign bus.o_div_a         = r_a;
  assign bus.o_div_b         = r_b;
  assign bus.o_div_res_ready = w_res_ready;
  assign bus.o_div_abort     = w_abort;
  assign bus.o_stall_e       = w_stall;
  assign bus.o_hilo_we       = w_we;
  assign bus.o_hilo_wdata    = w_wdata;
  assign bus.o_err_timeout   = w_expire;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
// ============================================================================
// Module   : tb_muldiv_ctrl
// Brief    : Self-checking bench for muldiv_ctrl with a behavioural divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int TO = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  muldiv_ctrl_if bus();

  muldiv_ctrl #(.DIV_TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected HI/LO writes, in order, plus a transaction-level view of the op
  logic [63:0] exp_q[$];
  logic        m_busy = 1'b0, m_hold = 1'b0, m_cool = 1'b0, m_sign = 1'b0;
  logic [31:0] m_a = '0, m_b = '0;
  int          m_run = 0;
  int          last_we_cyc = -1, err_cyc = -1, err_cnt = 0;

  always @(negedge clk) begin
    logic e_we, e_stall, e_abort, e_opn, e_ready, e_err, avail;
    e_we = 0; e_stall = 0; e_abort = 0; e_opn = 0; e_ready = 0; e_err = 0;
    if (!rst_n) begin
      m_busy = 0; m_hold = 0; m_cool = 0; m_run = 0;
      chk("reset_ctrl_outputs", {bus.o_stall_e, bus.o_hilo_we, bus.o_div_abort, bus.o_div_opn_valid,
          bus.o_div_res_ready, bus.o_err_timeout, bus.o_div_sign}, 64'd0);
      chk("reset_div_operands", {bus.o_div_a, bus.o_div_b}, 64'd0);
      chk("reset_wdata", bus.o_hilo_wdata, 64'd0);
    end else begin
      if (m_cool) begin
        m_cool = 0;
      end else if (!m_busy) begin
        if (bus.i_op_valid && !bus.i_flush_e) begin
          if (bus.i_op == MD_DIV || bus.i_op == MD_DIVU) begin
            e_stall = 1; m_busy = 1; m_hold = 0; m_run = 0;
            m_a = bus.i_src_a; m_b = bus.i_src_b; m_sign = (bus.i_op == MD_DIV);
          end else begin
            e_we = !bus.i_stall_m;
          end
        end
      end else if (bus.i_flush_e) begin
        e_abort = 1; m_busy = 0; m_hold = 0; m_cool = 1;
      end else begin
        e_opn = !m_hold;
        if (!m_hold) begin
          m_run++;
          e_err = (m_run == TO);
        end
        avail = m_hold || bus.i_div_res_valid;
        if (avail && !bus.i_stall_m) begin
          e_we = 1; e_ready = 1; m_busy = 0; m_hold = 0;
        end else begin
          e_stall = 1;
          m_hold  = avail;
        end
      end
      chk("stall_e", bus.o_stall_e, e_stall);
      chk("hilo_we", bus.o_hilo_we, e_we);
      chk("div_abort", bus.o_div_abort, e_abort);
      chk("div_opn_valid", bus.o_div_opn_valid, e_opn);
      chk("div_res_ready", bus.o_div_res_ready, e_ready);
      chk("err_timeout", bus.o_err_timeout, e_err);
      if (e_opn) begin
        chk("div_a_b", {bus.o_div_a, bus.o_div_b}, {m_a, m_b});
        chk("div_sign", bus.o_div_sign, m_sign);
      end
      if (bus.o_hilo_we) begin
        last_we_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_write: got %h, expected no write (cycle %0d)", bus.o_hilo_wdata, cyc);
        end else begin
          chk("hilo_wdata", bus.o_hilo_wdata, exp_q.pop_front());
        end
      end
      if (bus.o_err_timeout) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
  end

  // Divider: result from plain arithmetic, valid dv_lat run cycles later
  int          dv_lat = 34;
  logic        dv_busy = 1'b0, dv_valid = 1'b0;
  logic [63:0] dv_res = '0;
  int          dv_due = 0;

  function automatic logic [63:0] div_model(input logic s, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
    return {a % b, a / b};
  endfunction

  initial begin
    logic s_opn, s_ready, s_abort, s_rst, s_sign;
    logic [31:0] s_a, s_b;
    bus.i_div_res_valid = 1'b0;
    bus.i_div_result    = '0;
    forever begin
      @(negedge clk);
      s_opn = bus.o_div_opn_valid; s_ready = bus.o_div_res_ready; s_abort = bus.o_div_abort;
      s_rst = rst_n; s_sign = bus.o_div_sign; s_a = bus.o_div_a; s_b = bus.o_div_b;
      @(posedge clk);
      #1;
      if (!rst_n || !s_rst || s_abort) begin
        dv_busy = 0; dv_valid = 0;
      end else if (dv_valid && s_ready) begin
        dv_busy = 0; dv_valid = 0;
      end else if (!dv_busy && s_opn) begin
        dv_busy = 1;
        dv_res  = div_model(s_sign, s_a, s_b);
        dv_due  = cyc + dv_lat - 1;
      end
      if (dv_busy && !dv_valid && cyc >= dv_due) dv_valid = 1;
      bus.i_div_res_valid = dv_valid;
      bus.i_div_result    = dv_valid ? dv_res : 64'd0;
    end
  end

  function automatic logic [63:0] mul_model(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    if (op == MD_MULT) return 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
    return {32'd0, a} * {32'd0, b};
  endfunction

  int c0 = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    bus.i_op = op; bus.i_src_a = a; bus.i_src_b = b;
    bus.i_mul_result = mul_model(op, a, b);
    bus.i_op_valid = 1'b1;
    c0 = cyc;
    tick();
    bus.i_op_valid = 1'b0;
    bus.i_src_a = 32'h0BAD_0BAD; bus.i_src_b = 32'hB0B0_B0B0;
  endtask

  task automatic wait_quiet(input int max);
    int i = 0;
    do begin
      tick();
      i++;
    end while ((m_busy || exp_q.size() != 0) && i < max);
    chk("wait_bound_busy", {63'd0, m_busy}, 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int prev;
    bus.i_op_valid = 0; bus.i_op = MD_MULT; bus.i_src_a = 0; bus.i_src_b = 0;
    bus.i_hi_in = 0; bus.i_lo_in = 0; bus.i_flush_e = 0; bus.i_stall_m = 0;
    bus.i_mul_result = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFE);
    issue(MD_MULT, 32'hFFFF_FFFF, 32'd2);
    chk("mult_same_cycle", 64'(last_we_cyc), 64'(c0));

    bus.i_stall_m = 1;
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    bus.i_stall_m = 0;
    exp_q.push_back(64'd15);
    issue(MD_MULTU, 32'd3, 32'd5);

    bus.i_lo_in = 32'h0000_1234; bus.i_hi_in = 32'hCAFE_0000;
    bus.i_stall_m = 1;
    issue(MD_MTHI, 32'hDEAD_0000, 32'd0);
    bus.i_stall_m = 0;
    exp_q.push_back(64'hDEAD_0000_0000_1234);
    issue(MD_MTHI, 32'hDEAD_0000, 32'd0);
    exp_q.push_back(64'hCAFE_0000_0000_0055);
    issue(MD_MTLO, 32'h0000_0055, 32'd0);

    bus.i_flush_e = 1;
    issue(MD_MULT, 32'd7, 32'd7);
    bus.i_flush_e = 0;
    tick();

    dv_lat = 34;
    exp_q.push_back({32'd2, 32'd14});
    issue(MD_DIVU, 32'd100, 32'd7);
    wait_quiet(80);
    chk("divu_commit_cycle", 64'(last_we_cyc), 64'(c0 + 35));

    prev = last_we_cyc;
    dv_lat = 5;
    exp_q.push_back({32'd2, 32'hFFFF_FFFA});
    issue(MD_DIV, 32'd20, 32'hFFFF_FFFD);
    chk("b2b_issue_cycle", 64'(c0), 64'(prev + 1));
    wait_quiet(30);
    chk("b2b_commit_cycle", 64'(last_we_cyc), 64'(c0 + 6));

    dv_lat = 10;
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    repeat (10) tick();
    bus.i_stall_m = 1;
    repeat (3) tick();
    bus.i_stall_m = 0;
    wait_quiet(20);
    chk("hold_commit_cycle", 64'(last_we_cyc), 64'(c0 + 14));

    dv_lat = 34;
    prev = last_we_cyc;
    issue(MD_DIV, 32'd50, 32'd5);
    repeat (4) tick();
    bus.i_flush_e = 1;
    @(negedge clk);
    chk("flush_abort_pulse", bus.o_div_abort, 1);
    tick();
    bus.i_flush_e = 0;
    @(negedge clk);
    chk("flush_stall_low_1", bus.o_stall_e, 0);
    chk("flush_abort_one_cycle", bus.o_div_abort, 0);
    tick();
    @(negedge clk);
    chk("flush_stall_low_2", bus.o_stall_e, 0);
    wait_quiet(10);
    chk("flush_no_write", 64'(last_we_cyc), 64'(prev));

    dv_lat = 3;
    exp_q.push_back({32'd5, 32'hFFFF_FFFF});
    issue(MD_DIVU, 32'd5, 32'd0);
    wait_quiet(20);

    dv_lat = 41;
    err_cnt = 0;
    exp_q.push_back({32'd0, 32'd100});
    issue(MD_DIVU, 32'd1000, 32'd10);
    wait_quiet(100);
    chk("timeout_pulse_count", 64'(err_cnt), 64'd1);
    chk("timeout_pulse_cycle", 64'(err_cyc), 64'(c0 + 40));
    chk("timeout_commit_cycle", 64'(last_we_cyc), 64'(c0 + 42));

    dv_lat = 34;
    prev = last_we_cyc;
    issue(MD_DIVU, 32'd9, 32'd3);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_stall", bus.o_stall_e, 0);
    chk("async_rst_abort", bus.o_div_abort, 0);
    chk("async_rst_opn", bus.o_div_opn_valid, 0);
    chk("async_rst_we", bus.o_hilo_we, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("async_rst_no_write", 64'(last_we_cyc), 64'(prev));
    exp_q.push_back(64'd15);
    issue(MD_MULTU, 32'd3, 32'd5);
    wait_quiet(5);

    chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
